// File: rtl/node_gene_emitter.sv
// node_gene_emitter: allocates ids for new hidden nodes and emits packed node genes.
//
// Compile-time option: define NODE_EMIT_SKID_EN for a 2-entry skid output stage whose
// req_ready does not depend on gene_ready. Without it the output stage is one register.
//
// Ports:
//   clk                - clock, rising edge
//   rst                - synchronous active-high reset
//   start              - one-cycle pulse, seeds allocator from hidden_node_max_in
//   hidden_node_max_in - largest hidden node id currently in the genome
//   req_valid/ready    - new-node request handshake
//   req_bias, req_act  - attribute fields for the new node
//   gene_out           - packed node gene
//   gene_valid/ready   - gene output handshake
//   next_node_id       - id the next accepted request receives
//   id_overflow        - sticky, allocator exhausted
module node_gene_emitter #(
  parameter int unsigned GENE_SZ = 64,
  parameter int unsigned ATTR_SZ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ATTR_SZ-1:0] hidden_node_max_in,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ATTR_SZ-1:0] req_bias,
  input  logic [ATTR_SZ-1:0] req_act,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               gene_valid,
  input  logic               gene_ready,
  output logic [ATTR_SZ-1:0] next_node_id,
  output logic               id_overflow
);

  typedef enum logic [1:0] {StIdle, StArmed, StExhausted} state_e;

  localparam logic [ATTR_SZ-1:0] IdMax = '1;
  localparam logic [ATTR_SZ-1:0] IdOne = ATTR_SZ'(1);

  state_e             state_q, state_d;
  logic [ATTR_SZ-1:0] id_q, id_d;
  logic               ovf_q, ovf_d;

  logic               push, pop, space_ok;
  logic [GENE_SZ-1:0] new_gene;

  // Pack the gene from the current id and request fields; layer field stays 2'b00.
  always_comb begin
    new_gene = '0;
    new_gene[6*ATTR_SZ-1:5*ATTR_SZ] = id_q;
    new_gene[7*ATTR_SZ-2:7*ATTR_SZ-3] = 2'b00;
    new_gene[5*ATTR_SZ-1:4*ATTR_SZ] = req_bias;
    new_gene[4*ATTR_SZ-1:3*ATTR_SZ] = req_act;
  end

  // No acceptance while start is re-seeding the allocator.
  assign req_ready = (state_q == StArmed) && !start && space_ok;
  assign push      = req_valid && req_ready;
  assign pop       = gene_valid && gene_ready;

  assign next_node_id = id_q;
  assign id_overflow  = ovf_q;

`ifdef NODE_EMIT_SKID_EN
  // Two-entry skid buffer; ent0 is the head. Readiness uses only the registered count,
  // and a slot is still free at count 1, so one-per-cycle flow is sustained.
  logic [GENE_SZ-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]         cnt_q, cnt_d, cnt_mid;

  assign space_ok   = (cnt_q != 2'd2);
  assign gene_valid = (cnt_q != 2'd0);
  assign gene_out   = ent0_q;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_mid = cnt_q - {1'b0, pop};
    if (pop) begin
      ent0_d = ent1_q;
    end
    if (push) begin
      if (cnt_mid == 2'd0) begin
        ent0_d = new_gene;
      end else begin
        ent1_d = new_gene;
      end
    end
    cnt_d = cnt_mid + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  // Single output register; it can refill in the same cycle it is drained.
  logic [GENE_SZ-1:0] gene_q, gene_d;
  logic               vld_q, vld_d;

  assign space_ok   = !vld_q || gene_ready;
  assign gene_valid = vld_q;
  assign gene_out   = gene_q;

  always_comb begin
    gene_d = gene_q;
    vld_d  = vld_q;
    if (push) begin
      gene_d = new_gene;
      vld_d  = 1'b1;
    end else if (pop) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gene_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      gene_q <= gene_d;
      vld_q  <= vld_d;
    end
  end
`endif

  // Allocator FSM next state. start wins over a request (req_ready is low then anyway).
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    if (start) begin
      id_d = hidden_node_max_in + IdOne;
      if (hidden_node_max_in == IdMax) begin
        state_d = StExhausted;
        ovf_d   = 1'b1;
      end else begin
        state_d = StArmed;
        ovf_d   = 1'b0;
      end
    end else if (push) begin
      if (id_q == IdMax) begin
        // Last id handed out: its gene is emitted, the id counter parks at max.
        state_d = StExhausted;
        ovf_d   = 1'b1;
      end else begin
        id_d = id_q + IdOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_node_gene_emitter.sv
// tb_node_gene_emitter: table-driven directed bench for node_gene_emitter, plus
// hand-written sequences for backpressure, start with a pending gene, and reset priority.
module tb_node_gene_emitter;

`ifdef NODE_EMIT_SKID_EN
  localparam int Depth = 2;
`else
  localparam int Depth = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  hidden_node_max_in;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_bias;
  logic [7:0]  req_act;
  logic [63:0] gene_out;
  logic        gene_valid;
  logic        gene_ready;
  logic [7:0]  next_node_id;
  logic        id_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  node_gene_emitter #(
    .GENE_SZ(64),
    .ATTR_SZ(8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .hidden_node_max_in(hidden_node_max_in),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_bias          (req_bias),
    .req_act           (req_act),
    .gene_out          (gene_out),
    .gene_valid        (gene_valid),
    .gene_ready        (gene_ready),
    .next_node_id      (next_node_id),
    .id_overflow       (id_overflow)
  );

  typedef struct {
    logic        start;
    logic [7:0]  hid;
    logic        rv;
    logic [7:0]  bias;
    logic [7:0]  act;
    logic        gr;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_gene;
    logic [7:0]  e_next;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[18];

  // Reference gene layout for 8-bit attributes: [47:40] id, [39:32] bias, [31:24] act.
  function automatic logic [63:0] mk(input logic [7:0] id, input logic [7:0] b,
                                     input logic [7:0] a);
    return {16'h0000, id, b, a, 24'h000000};
  endfunction

  function automatic vec_t mkv(input logic st, input logic [7:0] hid, input logic rv,
                               input logic [7:0] b, input logic [7:0] a, input logic gr,
                               input logic er, input logic ev, input logic [63:0] eg,
                               input logic [7:0] en, input logic eo);
    vec_t v;
    v.start = st; v.hid = hid; v.rv = rv; v.bias = b; v.act = a; v.gr = gr;
    v.e_ready = er; v.e_valid = ev; v.e_gene = eg; v.e_next = en; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs just after the rising edge, return at the falling edge for sampling.
  task automatic cyc(input logic st, input logic [7:0] hid, input logic rv,
                     input logic [7:0] b, input logic [7:0] a, input logic gr);
    @(posedge clk);
    #1;
    start = st; hidden_node_max_in = hid; req_valid = rv;
    req_bias = b; req_act = a; gene_ready = gr;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] x;

    rst = 1'b1; start = 1'b0; hidden_node_max_in = 8'h00; req_valid = 1'b0;
    req_bias = 8'h00; req_act = 8'h00; gene_ready = 1'b1;

    //          st  hid   rv  bias   act    gr  rdy vld gene                  next   ovf
    vecs[0]  = mkv(1, 8'h05, 0, 8'h00, 8'h00, 1, 0, 0, 64'h0,                8'h00, 0);
    vecs[1]  = mkv(0, 8'h00, 1, 8'h11, 8'h22, 1, 1, 0, 64'h0,                8'h06, 0);
    vecs[2]  = mkv(0, 8'h00, 1, 8'h33, 8'h44, 1, 1, 1, mk(8'h06,8'h11,8'h22), 8'h07, 0);
    vecs[3]  = mkv(0, 8'h00, 1, 8'h55, 8'h66, 1, 1, 1, mk(8'h07,8'h33,8'h44), 8'h08, 0);
    vecs[4]  = mkv(0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1, mk(8'h08,8'h55,8'h66), 8'h09, 0);
    vecs[5]  = mkv(0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 0, 64'h0,                8'h09, 0);
    vecs[6]  = mkv(1, 8'h0F, 1, 8'hEE, 8'hEE, 1, 0, 0, 64'h0,                8'h09, 0);
    vecs[7]  = mkv(0, 8'h00, 1, 8'hA5, 8'h3C, 1, 1, 0, 64'h0,                8'h10, 0);
    vecs[8]  = mkv(0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1, 64'h0000_10A5_3C00_0000, 8'h11, 0);
    vecs[9]  = mkv(1, 8'hFE, 0, 8'h00, 8'h00, 1, 0, 0, 64'h0,                8'h11, 0);
    vecs[10] = mkv(0, 8'h00, 1, 8'h01, 8'h02, 1, 1, 0, 64'h0,                8'hFF, 0);
    vecs[11] = mkv(0, 8'h00, 1, 8'h03, 8'h04, 1, 0, 1, mk(8'hFF,8'h01,8'h02), 8'hFF, 1);
    vecs[12] = mkv(0, 8'h00, 1, 8'h03, 8'h04, 1, 0, 0, 64'h0,                8'hFF, 1);
    vecs[13] = mkv(1, 8'hFF, 0, 8'h00, 8'h00, 1, 0, 0, 64'h0,                8'hFF, 1);
    vecs[14] = mkv(0, 8'h00, 1, 8'h09, 8'h09, 1, 0, 0, 64'h0,                8'h00, 1);
    vecs[15] = mkv(1, 8'h30, 0, 8'h00, 8'h00, 1, 0, 0, 64'h0,                8'h00, 1);
    vecs[16] = mkv(0, 8'h00, 1, 8'h77, 8'h88, 1, 1, 0, 64'h0,                8'h31, 0);
    vecs[17] = mkv(0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1, mk(8'h31,8'h77,8'h88), 8'h32, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'(1'b0));
    chk("reset gene_valid", 64'(gene_valid), 64'(1'b0));
    chk("reset gene_out", gene_out, 64'h0);
    chk("reset next_node_id", 64'(next_node_id), 64'(8'h00));
    chk("reset id_overflow", 64'(id_overflow), 64'(1'b0));

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].start, vecs[i].hid, vecs[i].rv, vecs[i].bias, vecs[i].act, vecs[i].gr);
      chk($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
      chk($sformatf("row%0d gene_valid", i), 64'(gene_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("row%0d gene_out", i), gene_out, vecs[i].e_gene);
      end
      chk($sformatf("row%0d next_node_id", i), 64'(next_node_id), 64'(vecs[i].e_next));
      chk($sformatf("row%0d id_overflow", i), 64'(id_overflow), 64'(vecs[i].e_ovf));
    end

    // Backpressure: gene_ready low, only the buffer depth worth of requests accepted.
    cyc(0, 8'h00, 1, 8'h9A, 8'hBC, 0);
    chk("bp first ready", 64'(req_ready), 64'(1'b1));
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 8'h00, 1, 8'h9A, 8'hBC, 0);
      chk($sformatf("bp%0d gene_valid", k), 64'(gene_valid), 64'(1'b1));
      chk($sformatf("bp%0d gene_out", k), gene_out, mk(8'h32, 8'h9A, 8'hBC));
      chk($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'(k < Depth));
      chk($sformatf("bp%0d next_node_id", k), 64'(next_node_id),
          64'(8'(8'h32 + ((k < Depth) ? k : Depth))));
    end
    for (int d = 0; d < Depth; d++) begin
      cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
      chk($sformatf("drain%0d gene_valid", d), 64'(gene_valid), 64'(1'b1));
      chk($sformatf("drain%0d gene_out", d), gene_out, mk(8'(8'h32 + d), 8'h9A, 8'hBC));
    end
    cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
    chk("drain empty", 64'(gene_valid), 64'(1'b0));

    // start with one gene pending: gene survives, allocator re-seeds to 0x21.
    x = 8'(8'h32 + Depth);
    cyc(0, 8'h00, 1, 8'h01, 8'h02, 0);
    chk("pend accept ready", 64'(req_ready), 64'(1'b1));
    cyc(1, 8'h20, 0, 8'h00, 8'h00, 0);
    chk("pend start ready", 64'(req_ready), 64'(1'b0));
    chk("pend start gene", gene_out, mk(x, 8'h01, 8'h02));
    cyc(0, 8'h00, 0, 8'h00, 8'h00, 0);
    chk("pend hold valid", 64'(gene_valid), 64'(1'b1));
    chk("pend hold gene", gene_out, mk(x, 8'h01, 8'h02));
    chk("pend next_node_id", 64'(next_node_id), 64'(8'h21));
    cyc(0, 8'h00, 1, 8'h0A, 8'h0B, 1);
    chk("pend deliver gene", gene_out, mk(x, 8'h01, 8'h02));
    chk("pend deliver ready", 64'(req_ready), 64'(1'b1));
    cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
    chk("pend new gene", gene_out, mk(8'h21, 8'h0A, 8'h0B));
    chk("pend new valid", 64'(gene_valid), 64'(1'b1));
    chk("pend new next", 64'(next_node_id), 64'(8'h22));

    // Reset together with start and req_valid, with a gene pending.
    cyc(0, 8'h00, 1, 8'hCC, 8'hDD, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; hidden_node_max_in = 8'h05; req_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("rstpri req_ready", 64'(req_ready), 64'(1'b0));
    chk("rstpri gene_valid", 64'(gene_valid), 64'(1'b0));
    chk("rstpri gene_out", gene_out, 64'h0);
    chk("rstpri next_node_id", 64'(next_node_id), 64'(8'h00));
    chk("rstpri id_overflow", 64'(id_overflow), 64'(1'b0));
    cyc(0, 8'h00, 1, 8'h12, 8'h34, 1);
    chk("rstpri idle ready", 64'(req_ready), 64'(1'b0));
    cyc(0, 8'h00, 0, 8'h00, 8'h00, 1);
    chk("rstpri idle valid", 64'(gene_valid), 64'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/node_gene_emitter.md
NODE_GENE_EMITTER -- requirements
Module: node_gene_emitter

Interface
REQ-001 SHALL have parameter GENE_SZ, default 64, gene word width.
REQ-002 SHALL have parameter ATTR_SZ, default 8, attribute field width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; seeds the allocator from hidden_node_max_in.
REQ-006 SHALL have port hidden_node_max_in  input  ATTR_SZ  largest hidden node id currently in the genome.
REQ-007 SHALL have port req_valid  input  1  new-hidden-node request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-009 SHALL have port req_bias  input  ATTR_SZ  bias field for the new node.
REQ-010 SHALL have port req_act  input  ATTR_SZ  activation field for the new node.
REQ-011 SHALL have port gene_out  output  GENE_SZ  packed node gene.
REQ-012 SHALL have port gene_valid  output  1  gene_out holds a gene.
REQ-013 SHALL have port gene_ready  input  1  downstream consumes on gene_valid and gene_ready.
REQ-014 SHALL have port next_node_id  output  ATTR_SZ  id the next accepted request will receive.
REQ-015 SHALL have port id_overflow  output  1  sticky; allocator exhausted.

Function
REQ-016 SHALL implement FSM IDLE -> ARMED (on start) -> EXHAUSTED (on allocating id 2^ATTR_SZ-1); EXHAUSTED -> ARMED only on start.
REQ-017 On start, in any state, SHALL load next_node_id = hidden_node_max_in + 1 (modulo 2^ATTR_SZ) and clear id_overflow.
REQ-018 If hidden_node_max_in = 2^ATTR_SZ-1 at start, SHALL enter EXHAUSTED and set id_overflow the next cycle.
REQ-019 req_ready SHALL be low in IDLE, in EXHAUSTED, and in the cycle start is high.
REQ-020 In ARMED, req_ready SHALL be high when the output stage has a free slot.
REQ-021 Each accepted request SHALL produce exactly one gene, with node_id = next_node_id, then next_node_id increments by 1.
REQ-022 Gene packing: bits [6*ATTR_SZ-1:5*ATTR_SZ] = node_id; [7*ATTR_SZ-2:7*ATTR_SZ-3] = 2'b00 (hidden layer); [5*ATTR_SZ-1:4*ATTR_SZ] = req_bias; [4*ATTR_SZ-1:3*ATTR_SZ] = req_act; all other bits 0.
REQ-023 Latency from acceptance to gene_valid high SHALL be 1 cycle.
REQ-024 gene_out SHALL hold stable while gene_valid is high and gene_ready is low.
REQ-025 Accepting the request that allocates id 2^ATTR_SZ-1 SHALL set id_overflow and enter EXHAUSTED; that gene is still emitted; next_node_id holds at 2^ATTR_SZ-1.
REQ-026 Genes SHALL leave in acceptance order; none dropped or duplicated.
REQ-027 start while genes are pending SHALL NOT discard pending genes.

Reset
REQ-028 rst SHALL force IDLE, gene_valid=0, gene_out=0, next_node_id=0, id_overflow=0, req_ready=0, and empty the output stage.
REQ-029 rst SHALL take priority over start and all handshakes in the same cycle.

Configuration
REQ-030 Macro NODE_EMIT_SKID_EN defined: output stage SHALL be a 2-entry skid buffer; req_ready SHALL depend only on registered state (not on gene_ready), and full throughput (1 gene/cycle) SHALL be sustained under continuous gene_ready.
REQ-031 Macro NODE_EMIT_SKID_EN undefined: output stage SHALL be a single register; in ARMED, req_ready = !gene_valid || gene_ready.

Verification
REQ-032 rst, start with hidden_node_max_in=8'h05, 3 requests with gene_ready=1 -> genes with node_id 06, 07, 08; layer=00; next_node_id=09.
REQ-033 Request with req_bias=8'hA5, req_act=8'h3C, node_id 8'h10 -> gene_out = 64'h0000_10A5_3C00_0000.
REQ-034 start with hidden_node_max_in=8'hFE, 2 requests -> first gene node_id FE... corrected: first gene node_id FF, id_overflow=1, req_ready=0, second request not accepted.
REQ-035 gene_ready held low 5 cycles with a gene pending -> gene_out stable, no further acceptance beyond the buffer depth (1 undefined / 2 defined).
REQ-036 rst asserted concurrently with start and req_valid -> next cycle all outputs at reset values, state IDLE.
REQ-037 start issued with 1 gene pending and hidden_node_max_in=8'h20 -> pending gene delivered unchanged, next accepted gene node_id 21.
